// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory bus between fetch (IF) and load/store (D).
// One access in flight at a time; D has priority with a fairness override for IF.
module mem_port_arbiter #(
  parameter int unsigned FAIR_N   = 4,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wmask,
  input  logic [1:0]  d_size,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        d_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic [1:0]  mem_size,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        bus_err
);

  localparam logic [3:0] FAIR_MAX  = 4'(FAIR_N);
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        own_d;
  logic        own_d_nx;
  logic [3:0]  fair_cnt;
  logic [7:0]  wait_cnt;
  logic        grant;
  logic        pick_if;
  logic        busy;
  logic        rsp_take;
  logic        abort;
  logic [31:0] rsp_data;

  logic        mem_req_nx;
  logic        if_valid_nx;
  logic        d_valid_nx;
  logic [31:0] if_rdata_nx;
  logic [31:0] d_rdata_nx;
  logic        bus_err_nx;

  always_comb begin
    grant    = (state == S_IDLE) & (if_req | d_req);
    pick_if  = if_req & (~d_req | (fair_cnt == FAIR_MAX));
    busy     = (state == S_REQ) | (state == S_WAIT);
    rsp_take = mem_rvalid
             & (((state == S_REQ) & mem_gnt) | (state == S_WAIT));
    // timeout wins over a bare grant on the final allowed cycle
    abort    = busy & ~rsp_take & (wait_cnt == WAIT_LAST);
    own_d_nx = grant ? ~pick_if : own_d;
    rsp_data = (rsp_take & ~mem_we) ? mem_rdata : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      own_d     <= 1'b0;
      fair_cnt  <= '0;
      wait_cnt  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      mem_size  <= '0;
    end else begin
      state <= state_nx;
      own_d <= own_d_nx;
      if (busy && (state_nx == S_REQ || state_nx == S_WAIT))
        wait_cnt <= wait_cnt + 8'd1;
      else
        wait_cnt <= '0;
      if (grant) begin
        if (pick_if) begin
          fair_cnt  <= '0;
          mem_we    <= 1'b0;
          mem_addr  <= if_addr;
          mem_wdata <= '0;
          mem_wmask <= 4'b0000;
          mem_size  <= 2'b10;
        end else begin
          if (if_req && fair_cnt != FAIR_MAX)
            fair_cnt <= fair_cnt + 4'd1;
          mem_we    <= d_we;
          mem_addr  <= d_addr;
          mem_wdata <= d_wdata;
          mem_wmask <= d_wmask;
          mem_size  <= d_size;
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (if_req | d_req) state_nx = S_REQ;
      S_REQ: begin
        if (rsp_take | abort)
          state_nx = S_RESP;
        else if (mem_gnt)
          state_nx = S_WAIT;
      end
      S_WAIT: if (rsp_take | abort) state_nx = S_RESP;
      S_RESP: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req_nx  = (state_nx == S_REQ);
    if_valid_nx = (state_nx == S_RESP) & ~own_d_nx;
    d_valid_nx  = (state_nx == S_RESP) & own_d_nx;
    if_rdata_nx = if_valid_nx ? rsp_data : '0;
    d_rdata_nx  = d_valid_nx ? rsp_data : '0;
    bus_err_nx  = bus_err | abort;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req  <= 1'b0;
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
      bus_err  <= 1'b0;
    end else begin
      mem_req  <= mem_req_nx;
      if_valid <= if_valid_nx;
      d_valid  <= d_valid_nx;
      if_rdata <= if_rdata_nx;
      d_rdata  <= d_rdata_nx;
      bus_err  <= bus_err_nx;
    end
  end

  assign if_stall = if_req & ~if_valid;
  assign d_stall  = d_req & ~d_valid;

endmodule
